// File: rtl/fft_pkg.sv
// Shared constants and the FSM state type for the 16-point in-place FFT control path.
// The address LUT uses the same stage/butterfly widths.
package fft_pkg;

  localparam int FFT_N    = 16;
  localparam int N_STAGES = 4;
  localparam int N_BF     = 8;

  localparam int STAGE_W  = $clog2(N_STAGES);
  localparam int BF_W     = $clog2(N_BF);
  localparam int ADDR_W   = $clog2(FFT_N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } fft_state_t;

endpackage

// File: rtl/fft_addr_delay.sv
// Delays the read strobe and its A/B addresses by DEPTH cycles to form the write-back.
// Address fields only advance behind a valid entry, so the output holds the last written pair.
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_a,
  input  logic [ADDR_W-1:0] in_b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_a,
  output logic [ADDR_W-1:0] out_b
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] a_q [DEPTH];
  logic [ADDR_W-1:0] b_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= in_a;
        b_q[0] <= in_b;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          a_q[i] <= a_q[i-1];
          b_q[i] <= b_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks stage 0..3 x butterfly 0..7 of the in-place FFT, issues reads, and replays the
// addresses as write-back after the butterfly latency; drains between stages to avoid RAW hazards.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int BF_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [STAGE_W-1:0] stage_o,
  output logic [BF_W-1:0]    butterfly_o,
  input  logic [ADDR_W-1:0]  a_addr_i,
  input  logic [ADDR_W-1:0]  b_addr_i,
  output logic               rd_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_a_addr,
  output logic [ADDR_W-1:0]  wr_b_addr,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0]         DRAIN_INIT = 4'(BF_LATENCY);
  localparam logic [BF_W-1:0]    BF_LAST    = BF_W'(N_BF - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);

  fft_state_t         state, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BF_W-1:0]    bf_q, bf_d;
  logic [3:0]         drain_q, drain_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      drain_q <= drain_d;
    end
  end

  // The drain lets the last write of a stage land before the next stage's first read.
  always_comb begin
    state_d = state;
    stage_d = stage_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          stage_d = '0;
          bf_d    = '0;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (bf_q == BF_LAST) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          bf_d = bf_q + 1'b1;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) begin
          if (stage_q == STAGE_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            bf_d    = '0;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
        stage_d = '0;
        bf_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stage_o     = stage_q;
  assign butterfly_o = bf_q;

  fft_addr_delay #(
    .DEPTH(BF_LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_a     (a_addr_i),
    .in_b     (b_addr_i),
    .out_valid(wr_en),
    .out_a    (wr_a_addr),
    .out_b    (wr_b_addr)
  );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: three instances (latency 3, 1, 8) driven by a
// behavioural address LUT, with cycle-by-cycle expectations derived from the stage timing.
module tb_fft_stage_sequencer;

  logic       clk;
  logic       start_v [3];
  logic       rst_v   [3];
  logic       rd_en_v [3];
  logic       wr_en_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [1:0] stage_v [3];
  logic [2:0] bf_v    [3];
  logic [3:0] a_v     [3];
  logic [3:0] b_v     [3];
  logic [3:0] wa_v    [3];
  logic [3:0] wb_v    [3];

  int errors = 0;
  int checks = 0;

  // Run statistics filled by run_window
  int rd_cnt, wr_cnt, done_cnt, done_cyc;
  int bad_rd, bad_wr, bad_busy, bad_idx, bad_addr;
  int first_rd [4];
  int last_wr  [4];
  int wcount   [2][16];
  int rec_a [128];
  int rec_b [128];
  int rec_wa[128];
  int rec_wb[128];
  logic [7:0] sb[$];

  function automatic logic [3:0] lut_a(input logic [1:0] s, input logic [2:0] b);
    int span = 8 >> s;
    int ng   = 1 << s;
    return 4'(((int'(b) % ng) * 2 * span) + (int'(b) / ng));
  endfunction

  function automatic logic [3:0] lut_b(input logic [1:0] s, input logic [2:0] b);
    return lut_a(s, b) + 4'(8 >> s);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_stage_sequencer #(
      .BF_LATENCY((g == 0) ? 3 : ((g == 1) ? 1 : 8))
    ) dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .start      (start_v[g]),
      .stage_o    (stage_v[g]),
      .butterfly_o(bf_v[g]),
      .a_addr_i   (a_v[g]),
      .b_addr_i   (b_v[g]),
      .rd_en      (rd_en_v[g]),
      .wr_en      (wr_en_v[g]),
      .wr_a_addr  (wa_v[g]),
      .wr_b_addr  (wb_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g])
    );
    assign a_v[g] = lut_a(stage_v[g], bf_v[g]);
    assign b_v[g] = lut_b(stage_v[g], bf_v[g]);
  end

  // Drives start at relative cycles 0, e1, e2 and records what instance g does for ncyc cycles.
  task automatic run_window(input int g, input int lat, input int ncyc, input int e1, input int e2);
    int per  = 8 + lat;
    int last = 1 + 4 * per;
    int cw, ws;
    logic rexp, wexp, bexp;
    logic [7:0] pr;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    bad_rd = 0; bad_wr = 0; bad_busy = 0; bad_idx = 0; bad_addr = 0;
    sb.delete();
    for (int s = 0; s < 4; s++) begin first_rd[s] = -1; last_wr[s] = -1; end
    for (int p = 0; p < 2; p++) for (int a = 0; a < 16; a++) wcount[p][a] = 0;
    for (int c = 0; c < ncyc; c++) begin
      start_v[g] = (c == 0) || (c == e1) || (c == e2);
      rst_v[g]   = 1'b0;
      @(negedge clk);
      cw   = c - lat;
      rexp = (c >= 1) && (c < last) && (((c - 1) % per) < 8);
      wexp = (cw >= 1) && (cw < last) && (((cw - 1) % per) < 8);
      bexp = (c >= 1) && (c < last);
      if (rd_en_v[g] !== rexp) bad_rd++;
      if (wr_en_v[g] !== wexp) bad_wr++;
      if (busy_v[g] !== bexp) bad_busy++;
      if (c < 128) begin
        rec_a[c] = int'(a_v[g]);  rec_b[c] = int'(b_v[g]);
        rec_wa[c] = int'(wa_v[g]); rec_wb[c] = int'(wb_v[g]);
      end
      if (rd_en_v[g] === 1'b1) begin
        rd_cnt++;
        sb.push_back({a_v[g], b_v[g]});
        if (rexp && (stage_v[g] !== 2'((c - 1) / per) || bf_v[g] !== 3'((c - 1) % per))) bad_idx++;
        if (first_rd[stage_v[g]] < 0) first_rd[stage_v[g]] = c;
      end
      if (wr_en_v[g] === 1'b1) begin
        wr_cnt++;
        if (sb.size() == 0) bad_addr++;
        else begin
          pr = sb.pop_front();
          if (pr !== {wa_v[g], wb_v[g]}) bad_addr++;
        end
        ws = (cw >= 1) ? (cw - 1) / per : -1;
        if (ws >= 0 && ws < 4) begin
          last_wr[ws] = c;
          wcount[ws / 2][wa_v[g]]++;
          wcount[ws / 2][wb_v[g]]++;
        end
      end
      if (done_v[g] === 1'b1) begin done_cnt++; done_cyc = c; end
      @(posedge clk); #1;
    end
    start_v[g] = 1'b0;
  endtask

  task automatic test_reset();
    int rd_seen = 0;
    int busy_seen = 0;
    for (int g = 0; g < 3; g++) begin rst_v[g] = 1'b1; start_v[g] = 1'b0; end
    repeat (2) begin @(posedge clk); #1; end
    for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en_v[0], wr_en_v[0], busy_v[0], done_v[0]} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_strobes got=%b want=0000", {rd_en_v[0], wr_en_v[0], busy_v[0], done_v[0]});
    end
    checks++;
    if ({stage_v[0], bf_v[0]} !== 5'd0) begin
      errors++; $display("[TB] FAIL reset_counters got stage=%0d bf=%0d want 0/0", stage_v[0], bf_v[0]);
    end
    checks++;
    if ({wa_v[0], wb_v[0]} !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_wr_addr got a=%0d b=%0d want 0/0", wa_v[0], wb_v[0]);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (rd_en_v[g] !== 1'b0) rd_seen++;
        if (busy_v[g] !== 1'b0) busy_seen++;
      end
    end
    checks++;
    if (rd_seen != 0 || busy_seen != 0) begin
      errors++; $display("[TB] FAIL idle_no_activity got rd=%0d busy=%0d cycles want 0", rd_seen, busy_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_run();
    bit ok = 1'b1;
    run_window(0, 3, 50, -1, -1);
    checks++; if (bad_rd != 0) begin errors++; $display("[TB] FAIL full_rd_pattern got %0d bad cycles want 0", bad_rd); end
    checks++; if (bad_wr != 0) begin errors++; $display("[TB] FAIL full_wr_pattern got %0d bad cycles want 0", bad_wr); end
    checks++; if (bad_busy != 0) begin errors++; $display("[TB] FAIL full_busy got %0d bad cycles want 0", bad_busy); end
    checks++; if (done_cnt != 1 || done_cyc != 45) begin
      errors++; $display("[TB] FAIL full_done got %0d pulses at cycle %0d want 1 at 45", done_cnt, done_cyc);
    end
    checks++; if (rd_cnt != 32 || wr_cnt != 32) begin
      errors++; $display("[TB] FAIL full_counts got rd=%0d wr=%0d want 32/32", rd_cnt, wr_cnt);
    end
    checks++; if (bad_idx != 0) begin errors++; $display("[TB] FAIL full_stage_bf got %0d bad want 0", bad_idx); end
    checks++; if (bad_addr != 0) begin errors++; $display("[TB] FAIL full_wb_addr got %0d bad want 0", bad_addr); end
    checks++; if (rec_a[13] != 8 || rec_b[13] != 12) begin
      errors++; $display("[TB] FAIL s1bf1_read got %0d/%0d want 8/12", rec_a[13], rec_b[13]);
    end
    checks++; if (rec_wa[16] != 8 || rec_wb[16] != 12) begin
      errors++; $display("[TB] FAIL s1bf1_write got %0d/%0d want 8/12", rec_wa[16], rec_wb[16]);
    end
    checks++; if (rec_a[41] != 14 || rec_b[41] != 15) begin
      errors++; $display("[TB] FAIL s3bf7_read got %0d/%0d want 14/15", rec_a[41], rec_b[41]);
    end
    checks++; if (rec_wa[44] != 14 || rec_wb[44] != 15) begin
      errors++; $display("[TB] FAIL s3bf7_write got %0d/%0d want 14/15", rec_wa[44], rec_wb[44]);
    end
    checks++; if (rec_wa[47] != 14 || rec_wb[47] != 15) begin
      errors++; $display("[TB] FAIL wr_addr_hold got %0d/%0d want 14/15", rec_wa[47], rec_wb[47]);
    end
    for (int p = 0; p < 2; p++) for (int a = 0; a < 16; a++) if (wcount[p][a] != 2) ok = 1'b0;
    checks++; if (!ok) begin
      errors++; $display("[TB] FAIL addr_coverage got p0a0=%0d p1a0=%0d (some entry) want every count 2", wcount[0][0], wcount[1][0]);
    end
  endtask

  task automatic test_hazard(input int g, input int lat);
    run_window(g, lat, 75, -1, -1);
    checks++; if (bad_rd != 0 || bad_wr != 0) begin
      errors++; $display("[TB] FAIL hazard_L%0d_pattern got rd_bad=%0d wr_bad=%0d want 0/0", lat, bad_rd, bad_wr);
    end
    checks++; if (done_cnt != 1 || done_cyc != 1 + 4 * (8 + lat)) begin
      errors++; $display("[TB] FAIL hazard_L%0d_done got %0d pulses at %0d want 1 at %0d", lat, done_cnt, done_cyc, 1 + 4 * (8 + lat));
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (!(last_wr[s] >= 0 && first_rd[s+1] >= 0 && last_wr[s] < first_rd[s+1])) begin
        errors++;
        $display("[TB] FAIL hazard_L%0d_s%0d got last_wr=%0d next_rd=%0d want last_wr < next_rd", lat, s, last_wr[s], first_rd[s+1]);
      end
    end
  endtask

  task automatic test_start_ignored();
    run_window(0, 3, 46, 5, 45);
    checks++; if (bad_rd != 0 || done_cnt != 1 || done_cyc != 45 || rd_cnt != 32) begin
      errors++; $display("[TB] FAIL start_busy_run1 got rd_bad=%0d done=%0d@%0d reads=%0d want 0,1@45,32", bad_rd, done_cnt, done_cyc, rd_cnt);
    end
    run_window(0, 3, 50, -1, -1);
    checks++; if (bad_rd != 0 || bad_wr != 0) begin
      errors++; $display("[TB] FAIL start_idle_run2_pattern got rd_bad=%0d wr_bad=%0d want 0/0", bad_rd, bad_wr);
    end
    checks++; if (done_cnt != 1 || done_cyc != 45) begin
      errors++; $display("[TB] FAIL start_idle_run2_done got %0d pulses at rel %0d want 1 at 45 (abs 91)", done_cnt, done_cyc);
    end
  endtask

  task automatic test_rst_abort();
    int bad_after = 0;
    int done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      start_v[0] = (c == 0);
      rst_v[0]   = (c == 20);
      @(negedge clk);
      if (c >= 21 && (wr_en_v[0] !== 1'b0 || rd_en_v[0] !== 1'b0 || busy_v[0] !== 1'b0)) bad_after++;
      if (done_v[0] === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    rst_v[0] = 1'b0;
    checks++; if (bad_after != 0) begin
      errors++; $display("[TB] FAIL abort_quiet got %0d active cycles after rst want 0", bad_after);
    end
    checks++; if (done_seen != 0) begin
      errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", done_seen);
    end
    run_window(0, 3, 50, -1, -1);
    checks++; if (rd_cnt != 32 || wr_cnt != 32 || bad_addr != 0 || bad_wr != 0) begin
      errors++; $display("[TB] FAIL restart_clean got rd=%0d wr=%0d addr_bad=%0d wr_bad=%0d want 32,32,0,0", rd_cnt, wr_cnt, bad_addr, bad_wr);
    end
    checks++; if (done_cnt != 1 || done_cyc != 45) begin
      errors++; $display("[TB] FAIL restart_done got %0d pulses at rel %0d want 1 at 45 (abs 70)", done_cnt, done_cyc);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin start_v[g] = 1'b0; rst_v[g] = 1'b1; end
    test_reset();
    test_full_run();
    test_hazard(1, 1);
    test_hazard(2, 8);
    test_start_ignored();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
